// File: rtl/audio_pkg.sv
// Shared types for the I2S transmit path.
//   DW_DEF   : default sample width per channel
//   stereo_t : one stereo pair as read from the audio FIFO, {left, right}
//   state_t  : framing controller states
package audio_pkg;

    localparam int DW_DEF = 24;

    typedef struct packed {
        logic [DW_DEF-1:0] left;
        logic [DW_DEF-1:0] right;
    } stereo_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

endpackage

// File: rtl/i2s_tx_shift.sv
// Per-channel word register for the I2S serialiser.
// The word rotates rather than shifts, so after DW bit strobes it is back
// in its loaded form and lsb again shows the word's LSB; the controller
// relies on that to replay the LSB in the next channel's delay slot.
// Ports:
//   clk, rst_n : MCLK and asynchronous active-low reset
//   load       : load load_word (has priority over shift)
//   load_word  : next word for this channel
//   shift      : rotate one position towards the MSB
//   msb        : bit to transmit in the current data slot
//   lsb        : LSB of the word held
module i2s_tx_shift
    import audio_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_word,
    input  logic          shift,
    output logic          msb,
    output logic          lsb
);

    logic [DW-1:0] word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (load) begin
            word <= load_word;
        end else if (shift) begin
            word <= {word[DW-2:0], word[DW-1]};
        end
    end

    assign msb = word[DW-1];
    assign lsb = word[0];

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S master transmit framing controller (MCLK domain).
// Derives LRCLK/SCLK from a frame counter, fetches one stereo pair per frame
// from the audio FIFO and serialises it with the standard one-bit I2S delay.
// Ports:
//   clk, rst_n   : MCLK and asynchronous active-low reset
//   en           : run request; start and stop happen on frame boundaries
//   mute         : zero the next frame's data, sampled at the last frame cycle
//   fifo_empty   : FIFO empty flag
//   fifo_rd_en   : one-cycle FIFO read strobe
//   fifo_rdata   : {left, right}, valid the cycle after fifo_rd_en
//   lrclk, sclk, sdata : I2S outputs, registered and mutually aligned
//   frame_start  : one-cycle pulse when a frame's left channel begins
//   running      : high in RUN and STOP
//   uf_cnt       : saturating count of underflowed frames
module i2s_tx_ctrl
    import audio_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int FS_RATIO = 256,
    parameter int SCLK_DIV = 4,
    parameter int UF_CW    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mute,
    input  logic            fifo_empty,
    output logic            fifo_rd_en,
    input  logic [2*DW-1:0] fifo_rdata,
    output logic            lrclk,
    output logic            sclk,
    output logic            sdata,
    output logic            frame_start,
    output logic            running,
    output logic [UF_CW-1:0] uf_cnt
);

    localparam int FCW = $clog2(FS_RATIO);
    localparam logic [FCW-1:0] FC_LAST  = FCW'(FS_RATIO - 1);
    localparam logic [FCW-1:0] FC_FETCH = FCW'(FS_RATIO - 4);
    localparam logic [FCW-1:0] HALF     = FCW'(FS_RATIO / 2);
    localparam logic [FCW-1:0] SDIV     = FCW'(SCLK_DIV);
    localparam logic [FCW-1:0] SDIV_H   = FCW'(SCLK_DIV / 2);
    localparam logic [FCW-1:0] DWF      = FCW'(DW);

    // Every channel half needs the delay slot plus DW data slots.
    if (FS_RATIO / (2 * SCLK_DIV) < DW + 1) begin : g_bad_cfg
        $error("i2s_tx_ctrl: FS_RATIO/(2*SCLK_DIV) must be at least DW+1");
    end

    state_t          state, state_nx;
    logic [FCW-1:0]  fc, fc_nx;
    logic [FCW-1:0]  phase, slot;
    logic            is_right, bit_start, in_data;
    logic            load, shift_l, shift_r;
    logic [DW-1:0]   word_l, word_r;
    logic            msb_l, lsb_l, msb_r, lsb_r;
    logic            rd_d, pend_vld, carry;
    logic [2*DW-1:0] pend;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            fc    <= '0;
        end else begin
            state <= state_nx;
            fc    <= fc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        fc_nx    = '0;
        case (state)
            IDLE:    if (en) state_nx = RUN;
            RUN:     if (!en) state_nx = STOP;
            STOP: begin
                if (en) begin
                    state_nx = RUN;
                end else if (fc == FC_LAST) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // FS_RATIO is a power of two, so the increment wraps on its own.
        if (state != IDLE && state_nx != IDLE) begin
            fc_nx = fc + 1'b1;
        end
    end

    assign running = (state != IDLE);

    // ---------------------------------------------------------- slot decode
    assign phase     = fc % SDIV;
    assign slot      = (fc % HALF) / SDIV;
    assign is_right  = (fc >= HALF);
    assign bit_start = running && (phase == '0);
    assign in_data   = (slot != '0) && (slot <= DWF);
    assign shift_l   = bit_start && in_data && !is_right;
    assign shift_r   = bit_start && in_data && is_right;

    // Words change only at the frame's last cycle; while idle they are
    // held at zero so the first frame after a start is silent.
    assign load   = !running || (fc == FC_LAST);
    assign word_l = (running && pend_vld && !mute) ? pend[2*DW-1:DW] : '0;
    assign word_r = (running && pend_vld && !mute) ? pend[DW-1:0]    : '0;

    assign fifo_rd_en = (state == RUN) && (fc == FC_FETCH) && !fifo_empty;

    i2s_tx_shift #(.DW(DW)) u_shift_l (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_word (word_l),
        .shift     (shift_l),
        .msb       (msb_l),
        .lsb       (lsb_l)
    );

    i2s_tx_shift #(.DW(DW)) u_shift_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_word (word_r),
        .shift     (shift_r),
        .msb       (msb_r),
        .lsb       (lsb_r)
    );

    // ------------------------------------------------- fetch and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_d        <= 1'b0;
            pend_vld    <= 1'b0;
            pend        <= '0;
            carry       <= 1'b0;
            uf_cnt      <= '0;
            lrclk       <= 1'b0;
            sclk        <= 1'b0;
            sdata       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            rd_d <= fifo_rd_en;
            // Registered FIFO read: data arrives the cycle after the strobe.
            if (rd_d) begin
                pend     <= fifo_rdata;
                pend_vld <= 1'b1;
            end else if (load) begin
                pend_vld <= 1'b0;
            end

            // The right word is reloaded at the frame end, so its LSB must be
            // saved for the next left channel's delay slot.
            if (!running) begin
                carry <= 1'b0;
            end else if (fc == FC_LAST) begin
                carry <= lsb_r;
            end

            if (state == RUN && fc == FC_FETCH && fifo_empty && uf_cnt != '1) begin
                uf_cnt <= uf_cnt + 1'b1;
            end

            lrclk       <= running && is_right;
            sclk        <= running && (phase >= SDIV_H);
            frame_start <= running && (fc == '0);

            if (!running) begin
                sdata <= 1'b0;
            end else if (phase == '0) begin
                if (slot == '0) begin
                    sdata <= is_right ? lsb_l : carry;
                end else if (in_data) begin
                    sdata <= is_right ? msb_r : msb_l;
                end else begin
                    sdata <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Testbench for i2s_tx_ctrl: FIFO model, I2S receiver and a frame-level
// expectation queue; a second small instance exercises counter saturation.
module tb_i2s_tx_ctrl;

    localparam int DW  = 24;
    localparam int FS  = 256;
    localparam int SD  = 4;
    localparam int UFW = 16;
    localparam int NB  = FS / (2 * SD);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic mute = 1'b0;
    logic fifo_empty, fifo_rd_en;
    logic [2*DW-1:0] fifo_rdata = '0;
    logic lrclk, sclk, sdata, frame_start, running;
    logic [UFW-1:0] uf_cnt;

    logic rst2_n = 1'b0;
    logic en2 = 1'b1;
    logic mute2 = 1'b0;
    logic empty2 = 1'b1;
    logic [15:0] rdata2 = '0;
    logic rd2, lr2, sc2, sd2, fs2, run2;
    logic [2:0] uf2;

    always #5 clk = ~clk;

    i2s_tx_ctrl #(.DW(DW), .FS_RATIO(FS), .SCLK_DIV(SD), .UF_CW(UFW)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mute(mute), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .lrclk(lrclk), .sclk(sclk),
        .sdata(sdata), .frame_start(frame_start), .running(running), .uf_cnt(uf_cnt)
    );

    i2s_tx_ctrl #(.DW(8), .FS_RATIO(64), .SCLK_DIV(2), .UF_CW(3)) u_dut_sat (
        .clk(clk), .rst_n(rst2_n), .en(en2), .mute(mute2), .fifo_empty(empty2),
        .fifo_rd_en(rd2), .fifo_rdata(rdata2), .lrclk(lr2), .sclk(sc2),
        .sdata(sd2), .frame_start(fs2), .running(run2), .uf_cnt(uf2)
    );

    // FIFO model: registered read, data valid the cycle after the strobe.
    logic [2*DW-1:0] mem [0:255];
    int wp = 0;
    int rp = 0;
    int rd_cnt = 0;
    int rd_empty_err = 0;
    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (wp == rp) rd_empty_err <= rd_empty_err + 1;
            fifo_rdata <= mem[rp % 256];
            rp <= rp + 1;
            rd_cnt <= rd_cnt + 1;
        end
    end

    // I2S receiver: samples sdata on SCLK rising edges, slot 0 of each
    // channel carries the previous word's LSB, slots 1..DW MSB first.
    logic [DW-1:0] rxq[$];
    logic [DW-1:0] acc = '0;
    int slot_r = 0, idle_cyc = 100, k0_err = 0, pad_err = 0, len_err = 0;
    bit last_lr = 1'b1, prev_lsb = 1'b0, fresh = 1'b1, prev_sclk = 1'b0;
    int since_fs = 0, last_period = 0;

    always @(negedge clk) begin
        if (sclk && !prev_sclk) begin
            idle_cyc = 0;
            if (lrclk != last_lr) begin
                if (!fresh && slot_r != NB - 1) len_err++;
                fresh = 1'b0;
                slot_r = 0;
            end else begin
                slot_r++;
            end
            last_lr = lrclk;
            if (slot_r == 0) begin
                if (sdata !== prev_lsb) k0_err++;
            end else if (slot_r <= DW) begin
                acc = {acc[DW-2:0], sdata};
                if (slot_r == DW) begin
                    rxq.push_back(acc);
                    prev_lsb = sdata;
                end
            end else if (sdata !== 1'b0) begin
                pad_err++;
            end
        end else if (idle_cyc < 1000) begin
            idle_cyc++;
        end
        // A silent stretch means the transmitter stopped: the next left
        // channel starts fresh with a zero delay bit.
        if (idle_cyc > 2 * SD) begin
            last_lr = 1'b1;
            prev_lsb = 1'b0;
            fresh = 1'b1;
        end
        prev_sclk = sclk;
        if (frame_start) begin
            last_period = since_fs;
            since_fs = 1;
        end else begin
            since_fs++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    logic [2*DW-1:0] expq[$];
    int uf_exp = 0;
    int rd_mark = 0;
    int exp_rd = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [2*DW-1:0] w);
        mem[wp % 256] = w;
        wp++;
    endtask

    task automatic wait_fs(input int budget);
        tick(1);
        for (int c = 0; c < budget && frame_start !== 1'b1; c++) tick(1);
        chk("frame_start_seen", frame_start, 1);
    endtask

    task automatic check_prev();
        logic [2*DW-1:0] e;
        logic [DW-1:0] l, r;
        e = (expq.size() > 0) ? expq.pop_front() : '0;
        chk("rx_words", rxq.size(), 2);
        if (rxq.size() >= 2) begin
            l = rxq.pop_front();
            r = rxq.pop_front();
            chk("rx_left", l, e[2*DW-1:DW]);
            chk("rx_right", r, e[DW-1:0]);
        end
        rxq.delete();
    endtask

    // One frame: at its frame_start, verify the previous frame, then set up
    // what the FIFO and mute look like at this frame's fetch point.
    task automatic frame(input bit avail, input bit do_push, input bit mt,
                         input logic [2*DW-1:0] w, input bit contin, input bit stop);
        wait_fs(300);
        if (contin) begin
            chk("lrclk_period", last_period, FS);
            check_prev();
            chk("rd_per_frame", rd_cnt - rd_mark, exp_rd);
        end
        chk("uf_cnt", uf_cnt, uf_exp);
        rd_mark = rd_cnt;
        if (stop) begin
            en = 1'b0;
        end else begin
            mute = mt;
            if (do_push) push(w);
            expq.push_back((avail && !mt) ? w : '0);
            if (!avail) uf_exp++;
            exp_rd = avail ? 1 : 0;
        end
    endtask

    function automatic logic [2*DW-1:0] rnd_word();
        return {24'($urandom()), 24'($urandom())};
    endfunction

    initial begin
        logic [2*DW-1:0] w;
        bit av, mt;

        // Reset state
        tick(3);
        chk("rst_lrclk", lrclk, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_running", running, 0);
        chk("rst_uf_cnt", uf_cnt, 0);
        chk("rst_uf2", uf2, 0);
        rst_n = 1'b1;
        rst2_n = 1'b1;
        tick(5);
        chk("idle_running", running, 0);
        chk("idle_lrclk", lrclk, 0);

        // Preloaded pair, silent first frame, data in frame 2
        push({24'h800001, 24'h7FFFFE});
        en = 1'b1;
        expq.push_back('0);
        frame(1, 0, 0, {24'h800001, 24'h7FFFFE}, 0, 0);
        chk("fs_running", running, 1);
        chk("fs_lrclk_low", lrclk, 0);
        chk("fs_sclk_low", sclk, 0);
        tick(2);
        chk("sclk_high_mid_bit", sclk, 1);
        tick(125);
        chk("lrclk_left_end", lrclk, 0);
        tick(1);
        chk("lrclk_right_start", lrclk, 1);

        // Frame 2 fetches data; frame 3 hits an empty FIFO
        frame(1, 1, 0, rnd_word(), 1, 0);
        frame(0, 0, 0, '0, 1, 0);
        // Two muted frames still consume the FIFO
        frame(1, 1, 1, {24'h123456, 24'h123456}, 1, 0);
        frame(1, 1, 1, {24'h123456, 24'h123456}, 1, 0);
        frame(1, 1, 0, rnd_word(), 1, 0);

        // Randomized frames
        for (int i = 0; i < 8; i++) begin
            av = ($urandom_range(0, 3) != 0);
            mt = ($urandom_range(0, 4) == 0);
            frame(av, av, mt, rnd_word(), 1, 0);
        end

        // en dropped and restored within one frame: no gap
        frame(1, 1, 0, rnd_word(), 1, 0);
        tick(50);
        en = 1'b0;
        tick(30);
        chk("stop_still_running", running, 1);
        en = 1'b1;
        frame(1, 1, 0, rnd_word(), 1, 0);

        // en dropped: frame completes, then idle with no reads
        frame(0, 0, 0, '0, 1, 1);
        tick(300);
        check_prev();
        chk("stopped_running", running, 0);
        chk("stopped_lrclk", lrclk, 0);
        chk("stopped_sclk", sclk, 0);
        chk("stopped_sdata", sdata, 0);
        chk("stopped_reads", rd_cnt - rd_mark, 0);
        chk("stopped_uf_cnt", uf_cnt, uf_exp);

        // Restart from IDLE
        en = 1'b1;
        expq.push_back('0);
        frame(1, 1, 0, rnd_word(), 0, 0);
        frame(1, 1, 0, rnd_word(), 1, 0);
        frame(0, 0, 0, '0, 1, 0);

        // Asynchronous reset in the middle of a frame
        tick(99);
        rst_n = 1'b0;
        #1;
        chk("arst_lrclk", lrclk, 0);
        chk("arst_sclk", sclk, 0);
        chk("arst_sdata", sdata, 0);
        chk("arst_frame_start", frame_start, 0);
        chk("arst_running", running, 0);
        chk("arst_rd_en", fifo_rd_en, 0);
        chk("arst_uf_cnt", uf_cnt, 0);
        tick(20);
        rxq.delete();
        expq.delete();
        uf_exp = 0;
        rst_n = 1'b1;
        expq.push_back('0);
        frame(1, 1, 0, rnd_word(), 0, 0);
        frame(1, 1, 0, {24'hFFFFFF, 24'h000001}, 1, 0);
        frame(1, 1, 0, rnd_word(), 1, 0);
        frame(0, 0, 0, '0, 1, 0);
        frame(0, 0, 0, '0, 1, 1);
        tick(300);
        check_prev();
        chk("final_running", running, 0);

        // Saturation of the small instance, stable over a further frame
        chk("uf2_saturated", uf2, 3'd7);
        tick(64);
        chk("uf2_stays_saturated", uf2, 3'd7);

        chk("rx_delay_slot_errors", k0_err, 0);
        chk("rx_padding_errors", pad_err, 0);
        chk("rx_channel_length_errors", len_err, 0);
        chk("read_while_empty", rd_empty_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
